// File: rtl/i2s_codec_if.sv
// Sample-stream side of the I2S codec master: DAC pairs in (valid/ready),
// ADC pairs out (valid pulse), plus the underrun indication.
interface i2s_codec_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dac_left;
  logic [DATA_W-1:0] dac_right;
  logic              dac_valid;
  logic              dac_ready;
  logic [DATA_W-1:0] adc_left;
  logic [DATA_W-1:0] adc_right;
  logic              adc_valid;
  logic              underrun;

  // Stream producer/consumer (DMA/FIFO side).
  modport master (
    output dac_left, dac_right, dac_valid,
    input  dac_ready, adc_left, adc_right, adc_valid, underrun
  );

  // The codec master itself.
  modport slave (
    input  dac_left, dac_right, dac_valid,
    output dac_ready, adc_left, adc_right, adc_valid, underrun
  );
endinterface

// File: rtl/i2s_codec_master.sv
// I2S master for a slave-mode codec: qualifies PLL lock, generates BCLK/LRCK,
// shifts out DAC pairs and captures ADC pairs once per frame.
module i2s_codec_master #(
  parameter int DATA_W    = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 2,
  parameter int LOCK_WAIT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       enable_i,
  i2s_codec_if.slave strm,
  output logic       aud_bclk_o,
  output logic       aud_daclrck_o,
  output logic       aud_adclrck_o,
  output logic       aud_dacdat_o,
  input  logic       aud_adcdat_i
);

  localparam int BW    = $clog2(2 * SLOT_BITS);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int LCK_W = $clog2(LOCK_WAIT + 1);
  localparam int SH_W  = 2 * DATA_W;

  localparam logic [BW-1:0]    B_LAST   = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0]    B_SLOT   = BW'(SLOT_BITS);
  localparam logic [BW-1:0]    L_HI     = BW'(DATA_W);
  localparam logic [BW-1:0]    R_LO     = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0]    R_HI     = BW'(SLOT_BITS + DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [LCK_W-1:0] LCK_ARM  = LCK_W'(LOCK_WAIT - 1);
  localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_WAIT);

  typedef enum logic [1:0] {WAIT_LOCK, IDLE, RUN} state_e;

  state_e            state_q;
  logic              lock_meta_q, lock_sync_q;
  logic [LCK_W-1:0]  lock_cnt_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [SH_W-1:0]   tx_q, rx_q;
  logic [DIV_W-1:0]  div_q;
  logic [BW-1:0]     bit_q, bit_d;
  logic              bclk_q, lrck_q, dacdat_q;
  logic [DATA_W-1:0] adc_left_q, adc_right_q;
  logic              adc_valid_q, underrun_q;
  logic              tick, fall, rise, frame_end, load, xfer, dac_ready;

  // Periods 1..DATA_W of each slot carry data (one-bit I2S delay).
  function automatic logic in_data(input logic [BW-1:0] b);
    return (b != '0 && b <= L_HI) || (b >= R_LO && b <= R_HI);
  endfunction

  assign tick      = (state_q == RUN) && (div_q == DIV_LAST);
  assign fall      = tick && bclk_q;
  assign rise      = tick && !bclk_q;
  assign frame_end = fall && (bit_q == B_LAST);
  assign bit_d     = frame_end ? '0 : bit_q + BW'(1);
  assign load      = lock_sync_q && enable_i && ((state_q == IDLE) || frame_end);
  assign dac_ready = !hold_full_q && (state_q != WAIT_LOCK);
  assign xfer      = strm.dac_valid && dac_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here uses <= so all of them sample pre-edge values,
    // which the handshake/load overlap below depends on.
    if (rst) begin
      // NOTE: data registers are reset as well; they are flops, not a RAM,
      // so this costs nothing and keeps adc_left/right defined before the first frame.
      state_q     <= WAIT_LOCK;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      dacdat_q    <= 1'b0;
      adc_left_q  <= '0;
      adc_right_q <= '0;
      adc_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_sync_q <= lock_meta_q;
      adc_valid_q <= 1'b0;
      underrun_q  <= 1'b0;

      if (!lock_sync_q)              lock_cnt_q <= '0;
      else if (lock_cnt_q != LCK_MAX) lock_cnt_q <= lock_cnt_q + LCK_W'(1);

      if (!lock_sync_q) begin
        state_q     <= WAIT_LOCK;
        hold_full_q <= 1'b0;
        div_q       <= '0;
        bit_q       <= '0;
        bclk_q      <= 1'b0;
        lrck_q      <= 1'b0;
        dacdat_q    <= 1'b0;
      end else begin
        // A pair accepted on a load cycle lands in the register being emptied.
        if (xfer) begin
          hold_full_q <= 1'b1;
          hold_l_q    <= strm.dac_left;
          hold_r_q    <= strm.dac_right;
        end else if (load) begin
          hold_full_q <= 1'b0;
        end

        if (load) begin
          tx_q       <= hold_full_q ? {hold_l_q, hold_r_q} : '0;
          underrun_q <= !hold_full_q;
        end

        unique case (state_q)
          WAIT_LOCK: if (lock_cnt_q >= LCK_ARM) state_q <= IDLE;
          IDLE: if (enable_i) begin
            state_q <= RUN;
            div_q   <= '0;
            bit_q   <= '0;
            bclk_q  <= 1'b0;
          end
          RUN: begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) bclk_q <= !bclk_q;
            if (rise && in_data(bit_q)) rx_q <= {rx_q[SH_W-2:0], aud_adcdat_i};
            if (fall) begin
              bit_q  <= bit_d;
              lrck_q <= (bit_d >= B_SLOT);
              if (in_data(bit_d)) begin
                dacdat_q <= tx_q[SH_W-1];
                tx_q     <= tx_q << 1;
              end else begin
                dacdat_q <= 1'b0;
              end
              if (frame_end) begin
                adc_left_q  <= rx_q[SH_W-1:DATA_W];
                adc_right_q <= rx_q[DATA_W-1:0];
                adc_valid_q <= 1'b1;
                if (!enable_i) state_q <= IDLE;
              end
            end
          end
          default: state_q <= WAIT_LOCK;
        endcase
      end
    end
  end

  assign strm.dac_ready = dac_ready;
  assign strm.adc_left  = adc_left_q;
  assign strm.adc_right = adc_right_q;
  assign strm.adc_valid = adc_valid_q;
  assign strm.underrun  = underrun_q;
  assign aud_bclk_o     = bclk_q;
  assign aud_daclrck_o  = lrck_q;
  assign aud_adclrck_o  = lrck_q;
  assign aud_dacdat_o   = dacdat_q;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Self-checking bench for i2s_codec_master: pin-level frame decoder plus a
// holding-register/frame reference model, DACDAT looped back to ADCDAT.
module tb_i2s_codec_master;
  localparam int DW    = 16;
  localparam int SB    = 32;
  localparam int BH    = 2;
  localparam int LW    = 1024;
  localparam int FRAME = 4 * SB * BH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic enable = 1'b0;
  logic bclk, daclrck, adclrck, dacdat, adcdat;

  i2s_codec_if #(.DATA_W(DW)) strm ();

  i2s_codec_master #(
    .DATA_W(DW), .SLOT_BITS(SB), .BCLK_HALF(BH), .LOCK_WAIT(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked_i (pll_locked),
    .enable_i     (enable),
    .strm         (strm),
    .aud_bclk_o   (bclk),
    .aud_daclrck_o(daclrck),
    .aud_adclrck_o(adclrck),
    .aud_dacdat_o (dacdat),
    .aud_adcdat_i (adcdat)
  );

  assign adcdat = dacdat;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Serial image of one frame, bit b = value of DACDAT during BCLK period b.
  function automatic logic [63:0] exp_stream(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [63:0] s = '0;
    for (int b = 0; b < 2 * SB; b++) begin
      if (b >= 1 && b <= DW)                s[b] = l[DW - b];
      else if (b >= SB + 1 && b <= SB + DW) s[b] = r[DW - (b - SB)];
    end
    return s;
  endfunction

  // Stimulus-owned model state: pairs accepted by the DUT, and a flush mark.
  logic [DW-1:0] sent_l [0:63];
  logic [DW-1:0] sent_r [0:63];
  int xfer_cnt  = 0;
  int floor_idx = 0;

  // Monitor-owned state.
  int consumed  = 0;
  int mon_b     = -1;
  int adc_cnt   = 0;
  int m_urun    = 0;
  int m_low     = 0;
  int m_cyc     = 0;
  int m_rise    = 0;
  int m_start   = 0;
  int m_badper  = 0;
  int m_badws   = 0;
  int m_next    = 0;
  logic m_prev_bclk = 1'b0;
  logic m_last_lrck = 1'b0;
  logic m_prev_av   = 1'b0;
  logic [DW-1:0] cur_l = '0;
  logic [DW-1:0] cur_r = '0;
  logic [63:0] cap_dac  = '0;
  logic [63:0] cap_lrck = '0;

  initial begin
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst) begin
        if (strm.underrun) m_urun++;
        if (adclrck !== daclrck) m_badws++;
        if (strm.adc_valid) begin
          adc_cnt++;
          check("adc_pulse_width", m_prev_av, 1'b0);
          check("adc_left", strm.adc_left, cur_l);
          check("adc_right", strm.adc_right, cur_r);
        end
        m_prev_av = strm.adc_valid;
        if (bclk && !m_prev_bclk) begin
          if (m_low > BH || (!daclrck && m_last_lrck)) begin
            if (m_low <= BH) check("frame_period", m_cyc - m_start, FRAME);
            m_start  = m_cyc;
            mon_b    = 0;
            m_badper = 0;
            m_next   = (consumed > floor_idx) ? consumed : floor_idx;
            if (xfer_cnt > m_next) begin
              cur_l    = sent_l[m_next];
              cur_r    = sent_r[m_next];
              consumed = m_next + 1;
              check("underrun_at_start", m_urun, 0);
            end else begin
              cur_l    = '0;
              cur_r    = '0;
              consumed = m_next;
              check("underrun_at_start", m_urun, 1);
            end
            m_urun = 0;
          end else begin
            mon_b++;
            if (m_cyc - m_rise != 2 * BH) m_badper++;
          end
          m_rise = m_cyc;
          if (mon_b >= 0 && mon_b < 2 * SB) begin
            cap_dac[mon_b]  = dacdat;
            cap_lrck[mon_b] = daclrck;
          end else begin
            check("frame_length", mon_b, 2 * SB - 1);
          end
          m_last_lrck = daclrck;
          if (mon_b == 2 * SB - 1) begin
            check("dac_stream", cap_dac, exp_stream(cur_l, cur_r));
            check("lrck_pattern", cap_lrck, 64'hFFFF_FFFF_0000_0000);
            check("bclk_period_errs", m_badper, 0);
            check("adclrck_equals_daclrck", m_badws, 0);
          end
          m_low = 0;
        end else if (!bclk) begin
          m_low++;
        end
        m_prev_bclk = bclk;
      end
    end
  end

  task automatic wait_b(input int target);
    int t = 0;
    while (mon_b == target && t < 600) begin @(negedge clk); t++; end
    while (mon_b != target && t < 600) begin @(negedge clk); t++; end
    check("wait_bit_position", mon_b, target);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!strm.dac_ready && n < 2500) begin @(negedge clk); n++; end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    wait_ready(n);
    check("dac_ready_before_xfer", strm.dac_ready, 1'b1);
    strm.dac_left  = l;
    strm.dac_right = r;
    strm.dac_valid = 1'b1;
    @(negedge clk);
    strm.dac_valid = 1'b0;
    if (xfer_cnt < 64) begin
      sent_l[xfer_cnt] = l;
      sent_r[xfer_cnt] = r;
      xfer_cnt++;
    end
    check("dac_ready_after_xfer", strm.dac_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    int n;
    int a0;
    logic [3:0] pin_or;
    logic [DW-1:0] rl, rr;

    strm.dac_left  = '0;
    strm.dac_right = '0;
    strm.dac_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pins", {bclk, daclrck, adclrck, dacdat}, 4'b0);
    check("rst_dac_ready", strm.dac_ready, 1'b0);
    check("rst_adc_outputs", {strm.adc_valid, strm.underrun, strm.adc_left, strm.adc_right}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Lock qualification from a clean start: 2 sync stages + LOCK_WAIT.
    pll_locked = 1'b1;
    n = 0;
    pin_or = '0;
    while (!strm.dac_ready && n < 2500) begin
      @(negedge clk);
      n++;
      pin_or |= {bclk, daclrck, adclrck, dacdat};
    end
    check("lock_time_window", (n >= LW + 1 && n <= LW + 3), 1'b1);
    repeat (20) begin
      @(negedge clk);
      pin_or |= {bclk, daclrck, adclrck, dacdat};
    end
    check("pins_idle_before_enable", pin_or, 4'b0);

    // Lose lock, then restart counting and glitch once at about 500.
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    check("ready_low_after_lock_loss", strm.dac_ready, 1'b0);
    pll_locked = 1'b1;
    repeat (502) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_ready(n);
    check("relock_after_glitch_window", (n >= LW + 1 && n <= LW + 3), 1'b1);

    // Known pair first, then directed and random pairs; one frame left empty.
    send_pair(16'hA5C3, 16'h0F0F);
    enable = 1'b1;
    for (int f = 0; f < 10; f++) begin
      wait_b(20);
      if (f == 0)      send_pair(16'h1234, 16'h8765);
      else if (f == 1) send_pair(16'h7FFF, 16'h8000);
      else if (f != 4) begin
        rl = DW'($urandom());
        rr = DW'($urandom());
        send_pair(rl, rr);
      end
    end

    // enable drops mid-frame: frame completes, then pins idle.
    wait_b(10);
    enable = 1'b0;
    a0 = adc_cnt;
    n = 0;
    while (adc_cnt == a0 && n < 400) begin @(negedge clk); n++; end
    check("adc_pulses_on_stop", adc_cnt - a0, 1);
    pin_or = '0;
    repeat (100) begin
      @(negedge clk);
      pin_or |= {bclk, daclrck, adclrck, dacdat};
    end
    check("pins_idle_after_stop", pin_or, 4'b0);
    check("no_underrun_on_stop", m_urun, 0);

    // Restart, then lose lock mid-frame.
    send_pair(16'h55AA, 16'hC001);
    enable = 1'b1;
    wait_b(20);
    send_pair(16'h0001, 16'hFFFE);
    wait_b(10);
    pll_locked = 1'b0;
    a0 = adc_cnt;
    repeat (3) @(negedge clk);
    check("pins_zero_after_lock_drop", {bclk, daclrck, adclrck, dacdat}, 4'b0);
    check("ready_zero_after_lock_drop", strm.dac_ready, 1'b0);
    floor_idx = xfer_cnt;
    pin_or = '0;
    repeat (300) begin
      @(negedge clk);
      pin_or |= {bclk, daclrck, adclrck, dacdat};
    end
    check("pins_stay_zero_unlocked", pin_or, 4'b0);
    check("no_adc_valid_unlocked", adc_cnt - a0, 0);

    // Relock with enable held: first frame underruns, then normal traffic.
    pll_locked = 1'b1;
    wait_ready(n);
    check("ready_after_relock", strm.dac_ready, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_b(20);
      rl = DW'($urandom());
      rr = DW'($urandom());
      send_pair(rl, rr);
    end
    wait_b(5);
    enable = 1'b0;
    repeat (600) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
